// File: rtl/veririscv_avalon_arbiter_pkg.sv
// Shared types for the veriRISCV 2:1 Avalon-MM arbiter: bus request/response
// structs, owner IDs used in the response-routing FIFO and the grant FSM states.
package veririscv_avalon_arbiter_pkg;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  byteenable;
   } avalon_req_t;

   typedef struct packed {
      logic        waitrequest;
      logic        readdatavalid;
      logic [31:0] readdata;
   } avalon_resp_t;

   // Owner IDs stored in the outstanding-read FIFO
   localparam logic ARB_OWNER_IBUS = 1'b0;
   localparam logic ARB_OWNER_DBUS = 1'b1;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   // A host wants the bus whenever it drives a read or a write
   function automatic logic req_active(input avalon_req_t r);
      return r.read | r.write;
   endfunction

endpackage

// File: rtl/veririscv_avalon_arbiter_if.sv
// One Avalon-MM link: request travels master -> slave, response slave -> master.
interface veririscv_avalon_arbiter_if;
   import veririscv_avalon_arbiter_pkg::*;

   avalon_req_t  req;
   avalon_resp_t resp;

   // Handshake: a transfer is accepted in the cycle where the master holds
   // read|write and the slave returns waitrequest=0; the master keeps every
   // request field stable while waitrequest is high. Read data arrives later,
   // in order, qualified by readdatavalid, and is never back-pressured.
   modport master (output req, input  resp);
   modport slave  (input  req, output resp);

endinterface

// File: rtl/veririscv_avalon_arbiter_fifo.sv
// 1-bit-wide synchronous FIFO holding the owner ID of every read accepted by
// the device and not yet answered. Push is refused when full and pop when
// empty; full/empty always reflect the state before this cycle's update.
module veririscv_avalon_arbiter_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     din_i,
   output logic                     dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage; contents are meaningless while the FIFO is empty so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/veririscv_avalon_arbiter.sv
// 2:1 Avalon-MM arbiter merging the veriRISCV ibus and dbus onto one device
// port. Requests are muxed combinationally; read responses are routed back
// in order using an owner-ID FIFO. Fixed priority (dbus wins ties) by default;
// define VERIRISCV_AVALON_ARB_RR_EN for round-robin tie breaking.
module veririscv_avalon_arbiter
   import veririscv_avalon_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   veririscv_avalon_arbiter_if.slave      ibus_if,
   veririscv_avalon_arbiter_if.slave      dbus_if,
   veririscv_avalon_arbiter_if.master     dev_if,
   output logic                           err_orphan_o,
   output arb_state_e                     dbg_state_o,
   output logic [$clog2(MAX_OUTSTANDING):0] dbg_outstanding_o
);
   arb_state_e  state_q;
   logic        owner_q;
   logic        err_q;

   logic        i_act;
   logic        d_act;
   logic        tie_winner;
   logic        gnt_sel;
   logic        gnt_act;
   avalon_req_t gnt_req;
   avalon_req_t dev_req_mux;
   logic        read_blocked;
   logic        host_wait;
   logic        accept;
   logic        push;
   logic        pop;
   logic        orphan;
   logic        rdv;
   logic        head;
   logic        fifo_empty;
   logic        fifo_full;
   avalon_resp_t ibus_resp_mux;
   avalon_resp_t dbus_resp_mux;

   assign i_act = req_active(ibus_if.req);
   assign d_act = req_active(dbus_if.req);

`ifdef VERIRISCV_AVALON_ARB_RR_EN
   logic rr_q;

   // Priority pointer: after an accepted transfer the other host gets the tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rr_q <= ARB_OWNER_DBUS;
      else if (accept) rr_q <= ~gnt_sel;
   end

   assign tie_winner = rr_q;
`else
   assign tie_winner = ARB_OWNER_DBUS;
`endif

   // Grant selection: a held lock wins; otherwise arbitrate among active hosts.
   // An owner that drops its request releases the lock in the same cycle.
   always_comb begin
      gnt_sel = ARB_OWNER_DBUS;
      gnt_act = 1'b0;
      if (state_q == ARB_LOCKED && ((owner_q == ARB_OWNER_DBUS) ? d_act : i_act)) begin
         gnt_sel = owner_q;
         gnt_act = 1'b1;
      end else if (i_act && d_act) begin
         gnt_sel = tie_winner;
         gnt_act = 1'b1;
      end else if (d_act) begin
         gnt_sel = ARB_OWNER_DBUS;
         gnt_act = 1'b1;
      end else if (i_act) begin
         gnt_sel = ARB_OWNER_IBUS;
         gnt_act = 1'b1;
      end
   end

   assign gnt_req      = (gnt_sel == ARB_OWNER_DBUS) ? dbus_if.req : ibus_if.req;
   assign read_blocked = gnt_act && gnt_req.read && fifo_full;
   assign host_wait    = dev_if.resp.waitrequest | read_blocked;
   assign accept       = !rst && gnt_act && !host_wait;
   assign push         = accept && gnt_req.read;

   // Device request: granted host's fields, read suppressed while the FIFO is full
   always_comb begin
      dev_req_mux = gnt_req;
      if (read_blocked) dev_req_mux.read = 1'b0;
      if (rst || !gnt_act) dev_req_mux = '0;
   end

   assign dev_if.req = dev_req_mux;

   // Grant FSM: lock onto the granted host until its transfer is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= ARB_OWNER_IBUS;
      end else if (gnt_act && !accept) begin
         state_q <= ARB_LOCKED;
         owner_q <= gnt_sel;
      end else begin
         state_q <= ARB_IDLE;
      end
   end

   veririscv_avalon_arbiter_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (gnt_sel),
      .dout_o  (head),
      .count_o (dbg_outstanding_o),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign rdv    = !rst && dev_if.resp.readdatavalid;
   assign pop    = rdv && !fifo_empty;
   assign orphan = rdv && fifo_empty;

   // Host responses: waitrequest only to the granted host, read data to the FIFO head owner
   always_comb begin
      ibus_resp_mux             = '0;
      dbus_resp_mux             = '0;
      ibus_resp_mux.waitrequest = 1'b1;
      dbus_resp_mux.waitrequest = 1'b1;
      if (!rst && gnt_act) begin
         if (gnt_sel == ARB_OWNER_DBUS) dbus_resp_mux.waitrequest = host_wait;
         else                           ibus_resp_mux.waitrequest = host_wait;
      end
      if (pop) begin
         if (head == ARB_OWNER_DBUS) begin
            dbus_resp_mux.readdatavalid = 1'b1;
            dbus_resp_mux.readdata      = dev_if.resp.readdata;
         end else begin
            ibus_resp_mux.readdatavalid = 1'b1;
            ibus_resp_mux.readdata      = dev_if.resp.readdata;
         end
      end
   end

   assign ibus_if.resp = ibus_resp_mux;
   assign dbus_if.resp = dbus_resp_mux;

   // Sticky flag for a response beat that no outstanding read accounts for
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         err_q <= 1'b0;
      else if (orphan) err_q <= 1'b1;
   end

   assign err_orphan_o = err_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_veririscv_avalon_arbiter.sv
// Directed bench for veririscv_avalon_arbiter: arbitration order, lock hold,
// outstanding-read limit, in-order response routing, orphan detection and
// asynchronous reset with reads in flight.
module tb_veririscv_avalon_arbiter;
   import veririscv_avalon_arbiter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   avalon_req_t  ibus_req;
   avalon_req_t  dbus_req;
   avalon_resp_t dev_resp;
   logic         err_orphan;
   arb_state_e   dbg_state;
   logic [2:0]   dbg_outstanding;

   veririscv_avalon_arbiter_if ibus_bus ();
   veririscv_avalon_arbiter_if dbus_bus ();
   veririscv_avalon_arbiter_if dev_bus ();

   assign ibus_bus.req  = ibus_req;
   assign dbus_bus.req  = dbus_req;
   assign dev_bus.resp  = dev_resp;

   veririscv_avalon_arbiter #(
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .ibus_if           (ibus_bus),
      .dbus_if           (dbus_bus),
      .dev_if            (dev_bus),
      .err_orphan_o      (err_orphan),
      .dbg_state_o       (dbg_state),
      .dbg_outstanding_o (dbg_outstanding)
   );

   // ---------------- scoreboard ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] exp_q[$];   // {owner, readdata} of each expected response beat

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic host_req(input logic is_dbus, input logic rd, input logic wr,
                           input logic [31:0] addr);
      avalon_req_t r;
      r            = '0;
      r.read       = rd;
      r.write      = wr;
      r.address    = addr;
      r.writedata  = addr ^ 32'h5A5A_0000;
      r.byteenable = 4'hF;
      if (is_dbus) dbus_req = r;
      else         ibus_req = r;
   endtask

   task automatic dev_beat(input logic v, input logic [31:0] d);
      dev_resp.readdatavalid = v;
      dev_resp.readdata      = d;
   endtask

   // Bound the run in case the DUT or bench wedges
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [32:0] e;
      rst      = 1'b1;
      ibus_req = '0;
      dbus_req = '0;
      dev_resp = '0;
      #2;
      check("rst_ibus_wait",  32'(ibus_bus.resp.waitrequest),   32'd1);
      check("rst_ibus_rdv",   32'(ibus_bus.resp.readdatavalid), 32'd0);
      check("rst_ibus_data",  ibus_bus.resp.readdata,           32'd0);
      check("rst_dbus_wait",  32'(dbus_bus.resp.waitrequest),   32'd1);
      check("rst_dev_read",   32'(dev_bus.req.read),            32'd0);
      check("rst_dev_write",  32'(dev_bus.req.write),           32'd0);
      check("rst_err",        32'(err_orphan),                  32'd0);
      check("rst_state",      32'(dbg_state),                   32'(ARB_IDLE));
      check("rst_count",      32'(dbg_outstanding),             32'd0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check("idle_dev_read",  32'(dev_bus.req.read),            32'd0);

      // T1: simultaneous reads, dbus first then ibus
      host_req(1'b1, 1'b1, 1'b0, 32'h200);
      host_req(1'b0, 1'b1, 1'b0, 32'h100);
      #1;
      check("t1_c0_dev_addr",  dev_bus.req.address,             32'h200);
      check("t1_c0_dev_read",  32'(dev_bus.req.read),           32'd1);
      check("t1_c0_dbus_wait", 32'(dbus_bus.resp.waitrequest),  32'd0);
      check("t1_c0_ibus_wait", 32'(ibus_bus.resp.waitrequest),  32'd1);
      next_cycle();
      host_req(1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      check("t1_c1_dev_addr",  dev_bus.req.address,             32'h100);
      check("t1_c1_ibus_wait", 32'(ibus_bus.resp.waitrequest),  32'd0);
      check("t1_c1_dbus_wait", 32'(dbus_bus.resp.waitrequest),  32'd1);
      next_cycle();
      host_req(1'b0, 1'b0, 1'b0, 32'h0);
      check("t1_count",        32'(dbg_outstanding),            32'd2);
      dev_beat(1'b1, 32'h11);
      #1;
      check("t1_r0_dbus_rdv",  32'(dbus_bus.resp.readdatavalid), 32'd1);
      check("t1_r0_dbus_data", dbus_bus.resp.readdata,          32'h11);
      check("t1_r0_ibus_rdv",  32'(ibus_bus.resp.readdatavalid), 32'd0);
      next_cycle();
      dev_beat(1'b1, 32'h22);
      #1;
      check("t1_r1_ibus_rdv",  32'(ibus_bus.resp.readdatavalid), 32'd1);
      check("t1_r1_ibus_data", ibus_bus.resp.readdata,          32'h22);
      check("t1_r1_dbus_rdv",  32'(dbus_bus.resp.readdatavalid), 32'd0);
      next_cycle();
      dev_beat(1'b0, 32'h0);

      // T2: ibus read stalled 3 cycles holds the grant against a dbus write
      dev_resp.waitrequest = 1'b1;
      host_req(1'b0, 1'b1, 1'b0, 32'h100);
      #1;
      check("t2_c0_ibus_wait", 32'(ibus_bus.resp.waitrequest),  32'd1);
      check("t2_c0_dev_addr",  dev_bus.req.address,             32'h100);
      next_cycle();
      host_req(1'b1, 1'b0, 1'b1, 32'h300);
      #1;
      check("t2_c1_state",     32'(dbg_state),                  32'(ARB_LOCKED));
      check("t2_c1_dev_addr",  dev_bus.req.address,             32'h100);
      check("t2_c1_dev_write", 32'(dev_bus.req.write),          32'd0);
      check("t2_c1_dbus_wait", 32'(dbus_bus.resp.waitrequest),  32'd1);
      next_cycle();
      #1;
      check("t2_c2_dev_addr",  dev_bus.req.address,             32'h100);
      next_cycle();
      dev_resp.waitrequest = 1'b0;
      #1;
      check("t2_c3_ibus_wait", 32'(ibus_bus.resp.waitrequest),  32'd0);
      check("t2_c3_dbus_wait", 32'(dbus_bus.resp.waitrequest),  32'd1);
      next_cycle();
      host_req(1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      check("t2_c4_state",     32'(dbg_state),                  32'(ARB_IDLE));
      check("t2_c4_dev_write", 32'(dev_bus.req.write),          32'd1);
      check("t2_c4_dev_addr",  dev_bus.req.address,             32'h300);
      check("t2_c4_dev_wdata", dev_bus.req.writedata,           32'h5A5A_0300);
      check("t2_c4_dbus_wait", 32'(dbus_bus.resp.waitrequest),  32'd0);
      next_cycle();
      host_req(1'b1, 1'b0, 1'b0, 32'h0);
      dev_beat(1'b1, 32'h33);
      #1;
      check("t2_rsp_ibus_rdv", 32'(ibus_bus.resp.readdatavalid), 32'd1);
      check("t2_rsp_ibus_dat", ibus_bus.resp.readdata,          32'h33);
      next_cycle();
      dev_beat(1'b0, 32'h0);

      // T3: four accepted reads fill the FIFO, the fifth is held off
      host_req(1'b0, 1'b1, 1'b0, 32'h400);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("t3_accept%0d", k), 32'(ibus_bus.resp.waitrequest), 32'd0);
         next_cycle();
      end
      #1;
      check("t3_full_count",   32'(dbg_outstanding),            32'd4);
      check("t3_full_wait",    32'(ibus_bus.resp.waitrequest),  32'd1);
      check("t3_full_devread", 32'(dev_bus.req.read),           32'd0);
      next_cycle();
      dev_beat(1'b1, 32'h44);
      #1;
      check("t3_pop_rdv",      32'(ibus_bus.resp.readdatavalid), 32'd1);
      check("t3_pop_wait",     32'(ibus_bus.resp.waitrequest),  32'd1);
      check("t3_pop_devread",  32'(dev_bus.req.read),           32'd0);
      next_cycle();
      dev_beat(1'b0, 32'h0);
      #1;
      check("t3_after_wait",   32'(ibus_bus.resp.waitrequest),  32'd0);
      check("t3_after_devrd",  32'(dev_bus.req.read),           32'd1);
      next_cycle();
      host_req(1'b0, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         dev_beat(1'b1, 32'h50 + 32'(k));
         #1;
         check($sformatf("t3_drain_rdv%0d", k), 32'(ibus_bus.resp.readdatavalid), 32'd1);
         check($sformatf("t3_drain_dat%0d", k), ibus_bus.resp.readdata, 32'h50 + 32'(k));
         next_cycle();
      end
      dev_beat(1'b0, 32'h0);

      // T4: interleaved D,I,D reads answered in order
      host_req(1'b1, 1'b1, 1'b0, 32'h500);
      exp_q.push_back({ARB_OWNER_DBUS, 32'hAAAA});
      #1;
      check("t4_d0_wait",      32'(dbus_bus.resp.waitrequest),  32'd0);
      next_cycle();
      host_req(1'b1, 1'b0, 1'b0, 32'h0);
      host_req(1'b0, 1'b1, 1'b0, 32'h504);
      exp_q.push_back({ARB_OWNER_IBUS, 32'hBBBB});
      #1;
      check("t4_i1_wait",      32'(ibus_bus.resp.waitrequest),  32'd0);
      next_cycle();
      host_req(1'b0, 1'b0, 1'b0, 32'h0);
      host_req(1'b1, 1'b1, 1'b0, 32'h508);
      exp_q.push_back({ARB_OWNER_DBUS, 32'hCCCC});
      #1;
      check("t4_d2_wait",      32'(dbus_bus.resp.waitrequest),  32'd0);
      next_cycle();
      host_req(1'b1, 1'b0, 1'b0, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         dev_beat(1'b1, e[31:0]);
         #1;
         if (e[32] == ARB_OWNER_DBUS) begin
            check("t4_dbus_rdv",  32'(dbus_bus.resp.readdatavalid), 32'd1);
            check("t4_dbus_data", dbus_bus.resp.readdata,           e[31:0]);
            check("t4_ibus_quiet",32'(ibus_bus.resp.readdatavalid), 32'd0);
         end else begin
            check("t4_ibus_rdv",  32'(ibus_bus.resp.readdatavalid), 32'd1);
            check("t4_ibus_data", ibus_bus.resp.readdata,           e[31:0]);
            check("t4_dbus_quiet",32'(dbus_bus.resp.readdatavalid), 32'd0);
         end
         next_cycle();
      end
      dev_beat(1'b0, 32'h0);

      // T5: response with nothing outstanding is an orphan
      dev_beat(1'b1, 32'hDEAD);
      #1;
      check("t5_ibus_rdv",     32'(ibus_bus.resp.readdatavalid), 32'd0);
      check("t5_dbus_rdv",     32'(dbus_bus.resp.readdatavalid), 32'd0);
      check("t5_err_before",   32'(err_orphan),                 32'd0);
      next_cycle();
      dev_beat(1'b0, 32'h0);
      #1;
      check("t5_err_set",      32'(err_orphan),                 32'd1);
      next_cycle();
      next_cycle();
      check("t5_err_sticky",   32'(err_orphan),                 32'd1);

      // T6: asynchronous reset with two reads outstanding and a third stalled
      host_req(1'b1, 1'b1, 1'b0, 32'h600);
      next_cycle();
      host_req(1'b1, 1'b0, 1'b0, 32'h0);
      host_req(1'b0, 1'b1, 1'b0, 32'h604);
      next_cycle();
      dev_resp.waitrequest = 1'b1;
      host_req(1'b0, 1'b1, 1'b0, 32'h608);
      next_cycle();
      check("t6_pre_count",    32'(dbg_outstanding),            32'd2);
      check("t6_pre_state",    32'(dbg_state),                  32'(ARB_LOCKED));
      #1;
      rst = 1'b1;
      #1;
      check("t6_ibus_wait",    32'(ibus_bus.resp.waitrequest),  32'd1);
      check("t6_dbus_wait",    32'(dbus_bus.resp.waitrequest),  32'd1);
      check("t6_dev_read",     32'(dev_bus.req.read),           32'd0);
      check("t6_count",        32'(dbg_outstanding),            32'd0);
      check("t6_state",        32'(dbg_state),                  32'(ARB_IDLE));
      check("t6_err_clr",      32'(err_orphan),                 32'd0);
      next_cycle();
      host_req(1'b0, 1'b0, 1'b0, 32'h0);
      dev_resp.waitrequest = 1'b0;
      next_cycle();
      rst = 1'b0;
      dev_beat(1'b1, 32'h77);
      #1;
      check("t6_late_ibus",    32'(ibus_bus.resp.readdatavalid), 32'd0);
      check("t6_late_dbus",    32'(dbus_bus.resp.readdatavalid), 32'd0);
      next_cycle();
      dev_beat(1'b0, 32'h0);
      #1;
      check("t6_orphan",       32'(err_orphan),                 32'd1);

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
